uart_inst_loader: RTL and testbench
===================================

Name: uart_inst_loader

Overview:
- Boot-time program loader between the UART byte receiver (rx byte + data-valid pulse) and the ICCM write port.
- Assembles received bytes into little-endian 32-bit instruction words and writes them to consecutive ICCM addresses.
- On the end-of-program marker word, holds the core in reset until en_i, then releases system_rst_no.

Parameters:
- DATA_WIDTH, 32, instruction/ICCM word width; only 32 supported.
- BASE_ADDR, 32'h0000_0000, byte address of the first ICCM word.
- ICCM_DEPTH, 1024, capacity in words.
- END_WORD, 32'h0000_0FFF, end-of-program marker; not written to ICCM.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  level; permits core start after load completes
- rx_byte_i  in  8  received UART byte
- rx_dv_i  in  1  one-cycle pulse; rx_byte_i valid
- iccm_req_o  out  1  write request
- iccm_we_o  out  1  write enable; equals iccm_req_o
- iccm_addr_o  out  32  byte address
- iccm_wdata_o  out  DATA_WIDTH  write data
- iccm_be_o  out  4  byte enables; 4'hF while iccm_req_o is high, else 0
- iccm_gnt_i  in  1  write accepted this cycle
- system_rst_no  out  1  active-low core reset
- load_done_o  out  1  end marker received
- word_count_o  out  $clog2(ICCM_DEPTH)+1  words written
- overrun_o  out  1  sticky: byte lost
- full_o  out  1  sticky: ICCM capacity exceeded

Behaviour:
- Reset (async assert, sync deassert):
  - all outputs 0, including system_rst_no (core held in reset).
  - byte index, word count, skid buffer and state cleared; state COLLECT.
- Byte assembly: byte index k = 0..3 stores rx_byte_i into word[8k+7:8k]. The first byte received is the LSB.
- States:
  - COLLECT: on rx_dv_i, store byte and increment k.
    - On the 4th byte, the completed word is registered next cycle.
    - If word == END_WORD: go to DONE; word not written.
    - Else if word_count == ICCM_DEPTH: set full_o, discard word, stay in COLLECT.
    - Else: go to WRITE.
  - WRITE:
    - iccm_req_o = 1, iccm_addr_o = BASE_ADDR + 4*word_count, iccm_wdata_o = word.
    - Address, data and request are held stable until iccm_gnt_i.
    - On the gnt cycle: word_count increments, req drops the next cycle, return to COLLECT.
    - Latency: first req cycle is 2 cycles after the 4th rx_dv_i (one cycle to register the word, one to enter WRITE).
  - DONE:
    - load_done_o = 1; further rx_dv_i ignored, no flags set.
    - When en_i = 1, go to RUN.
  - RUN: system_rst_no = 1. Terminal until rst_ni.
- Skid buffer:
  - A byte arriving in WRITE (or in the word-registration cycle) is held in a 1-entry skid register and consumed on return to COLLECT.
  - A second byte while the skid register is full is dropped and sets overrun_o. The held byte is kept.
- iccm_gnt_i outside WRITE is ignored.
- en_i before load completes has no effect. It is sampled only in DONE, so en_i already high sends DONE→RUN on the next cycle.
- Simultaneous rx_dv_i and iccm_gnt_i in WRITE: the byte goes to skid, the write completes, and both take effect.
- Reset mid-WRITE: req drops immediately and the partial word is lost. The next load restarts at BASE_ADDR.
- word_count saturates at ICCM_DEPTH.

Test Plan:
- Bytes 13,01,20,00, then FF,0F,00,00, gnt held high
  - one write: addr 0x0, data 32'h0020_0113, be 4'hF
  - load_done_o=1, word_count_o=1, system_rst_no=0
- Same load with gnt delayed 5 cycles
  - req/addr/data stable for 5 cycles; exactly one write.
- After load_done_o, assert en_i
  - system_rst_no=1 one cycle later.
  - with en_i=1 throughout load: system_rst_no rises one cycle after load_done_o.
- Gnt held low, 2 further rx_dv_i pulses during WRITE
  - first byte buffered and later assembled as byte 0 of the next word.
  - second byte dropped; overrun_o=1.
- ICCM_DEPTH=4, send 5 normal words then END_WORD
  - 4 writes at 0x0,0x4,0x8,0xC; full_o=1; word_count_o=4.
  - load_done_o=1.
- rst_ni low during WRITE of word 2, then reload 1 word + END_WORD
  - outputs 0 immediately on reset.
  - new write at addr 0x0; word_count_o=1.

Source files
------------

// File: rtl/uart_inst_loader.sv
// ---------------------------------------------------------------------------
// uart_inst_loader
//
// Boot-time program loader. Sits between a UART byte receiver and the ICCM
// write port. Received bytes are packed little-endian into 32-bit instruction
// words, and each word is written to the next ICCM address. When the
// end-of-program marker arrives, the core stays in reset until en_i is high.
// Then system_rst_no is released.
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset (asserts at once, releases
//                  synchronously)
//   en_i           level; lets the core start once loading is complete
//   rx_byte_i      received UART byte
//   rx_dv_i        one-cycle strobe; rx_byte_i is valid
//   iccm_req_o     write request
//   iccm_we_o      write enable; same as iccm_req_o
//   iccm_addr_o    byte address of the word being written
//   iccm_wdata_o   write data
//   iccm_be_o      byte enables; all set while requesting
//   iccm_gnt_i     write accepted this cycle
//   system_rst_no  active-low core reset
//   load_done_o    end marker received
//   word_count_o   number of words written
//   overrun_o      sticky; a received byte was lost
//   full_o         sticky; a word arrived after the ICCM was full
// ---------------------------------------------------------------------------
module uart_inst_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned ICCM_DEPTH = 1024,
    parameter logic [31:0] END_WORD   = 32'h0000_0FFF
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic [7:0]                    rx_byte_i,
    input  logic                          rx_dv_i,
    output logic                          iccm_req_o,
    output logic                          iccm_we_o,
    output logic [31:0]                   iccm_addr_o,
    output logic [DATA_WIDTH-1:0]         iccm_wdata_o,
    output logic [3:0]                    iccm_be_o,
    input  logic                          iccm_gnt_i,
    output logic                          system_rst_no,
    output logic                          load_done_o,
    output logic [$clog2(ICCM_DEPTH):0]   word_count_o,
    output logic                          overrun_o,
    output logic                          full_o
);

    // state    | meaning
    // ---------+-------------------------------------------------------------
    // COLLECT  | assembling bytes of the next word
    // REG      | word complete; decide between write, discard and end marker
    // WRITE    | ICCM request held until granted
    // DONE     | end marker seen; core held in reset until en_i
    // RUN      | core released; terminal until reset

    localparam int unsigned CNT_W = $clog2(ICCM_DEPTH) + 1;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_REG     = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_RUN     = 3'd4
    } state_t;

    state_t                 state_q, state_d;

    logic                   rst_meta, rst_sync_n;
    logic [1:0]             byte_idx;
    logic [DATA_WIDTH-1:0]  word;
    logic [7:0]             skid_byte;
    logic                   skid_vld;
    logic [CNT_W-1:0]       word_count;
    logic                   overrun;
    logic                   full;

    logic                   take_byte;
    logic [7:0]             next_byte;
    logic                   hold_phase;
    logic                   cnt_at_max;
    logic                   is_end;
    logic [31:0]            addr_offset;

    // Reset asserts asynchronously and releases on a clock edge, so all
    // state flops leave reset together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    // A held skid byte is older than anything on rx, so it is consumed first.
    assign take_byte   = (state_q == ST_COLLECT) && (skid_vld || rx_dv_i);
    assign next_byte   = skid_vld ? skid_byte : rx_byte_i;
    assign hold_phase  = (state_q == ST_REG) || (state_q == ST_WRITE);
    assign cnt_at_max  = (word_count == CNT_W'(ICCM_DEPTH));
    assign is_end      = (word == END_WORD);
    assign addr_offset = 32'(word_count) << 2;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: begin
                if (take_byte && (byte_idx == 2'd3)) begin
                    state_d = ST_REG;
                end
            end
            ST_REG: begin
                if (is_end) begin
                    state_d = ST_DONE;
                end else if (cnt_at_max) begin
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (iccm_gnt_i) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_DONE: begin
                if (en_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_comb begin
        iccm_req_o    = 1'b0;
        iccm_addr_o   = '0;
        iccm_wdata_o  = '0;
        iccm_be_o     = 4'h0;
        load_done_o   = 1'b0;
        system_rst_no = 1'b0;
        case (state_q)
            ST_WRITE: begin
                iccm_req_o   = 1'b1;
                iccm_addr_o  = BASE_ADDR + addr_offset;
                iccm_wdata_o = word;
                iccm_be_o    = 4'hF;
            end
            ST_DONE: begin
                load_done_o = 1'b1;
            end
            ST_RUN: begin
                load_done_o   = 1'b1;
                system_rst_no = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign iccm_we_o    = iccm_req_o;
    assign word_count_o = word_count;
    assign overrun_o    = overrun;
    assign full_o       = full;

    // ------------------------------------------------------------- datapath
    // The assembled word is left untouched from REG until the write finishes.
    // Bytes arriving in that window go to the skid register instead.
    always_ff @(posedge clk_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            byte_idx   <= 2'd0;
            word       <= '0;
            skid_byte  <= 8'h00;
            skid_vld   <= 1'b0;
            word_count <= '0;
            overrun    <= 1'b0;
            full       <= 1'b0;
        end else begin
            if (take_byte) begin
                word[{byte_idx, 3'b000} +: 8] <= next_byte;
                byte_idx                      <= byte_idx + 2'd1;
            end

            if (state_q == ST_COLLECT) begin
                // Skid byte consumed this cycle; a simultaneous rx byte refills it.
                if (skid_vld) begin
                    if (rx_dv_i) begin
                        skid_byte <= rx_byte_i;
                    end else begin
                        skid_vld <= 1'b0;
                    end
                end
            end else if (hold_phase && rx_dv_i) begin
                if (!skid_vld) begin
                    skid_byte <= rx_byte_i;
                    skid_vld  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end

            if ((state_q == ST_WRITE) && iccm_gnt_i && !cnt_at_max) begin
                word_count <= word_count + CNT_W'(1);
            end

            if ((state_q == ST_REG) && !is_end && cnt_at_max) begin
                full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_inst_loader.sv
module tb_uart_inst_loader;

    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] END_W = 32'h0000_0FFF;

    logic           clk_i;
    logic           rst_ni;
    logic           en_i;
    logic [7:0]     rx_byte_i;
    logic           rx_dv_i;
    logic           iccm_req_o;
    logic           iccm_we_o;
    logic [31:0]    iccm_addr_o;
    logic [31:0]    iccm_wdata_o;
    logic [3:0]     iccm_be_o;
    logic           iccm_gnt_i;
    logic           system_rst_no;
    logic           load_done_o;
    logic [CW-1:0]  word_count_o;
    logic           overrun_o;
    logic           full_o;

    uart_inst_loader #(
        .DATA_WIDTH (32),
        .BASE_ADDR  (32'h0000_0000),
        .ICCM_DEPTH (DEPTH),
        .END_WORD   (END_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .rx_byte_i     (rx_byte_i),
        .rx_dv_i       (rx_dv_i),
        .iccm_req_o    (iccm_req_o),
        .iccm_we_o     (iccm_we_o),
        .iccm_addr_o   (iccm_addr_o),
        .iccm_wdata_o  (iccm_wdata_o),
        .iccm_be_o     (iccm_be_o),
        .iccm_gnt_i    (iccm_gnt_i),
        .system_rst_no (system_rst_no),
        .load_done_o   (load_done_o),
        .word_count_o  (word_count_o),
        .overrun_o     (overrun_o),
        .full_o        (full_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Reference model: the ICCM should see the non-marker words in arrival
    // order at consecutive addresses, until capacity runs out.
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] wlist[$];
    int          model_count;
    bit          model_full;
    int          writes_seen = 0;
    int          last_req_len = 0;

    task automatic expect_word(input logic [31:0] w);
        if (w != END_W) begin
            if (model_count < DEPTH) begin
                exp_addr_q.push_back(32'(model_count * 4));
                exp_data_q.push_back(w);
                model_count++;
            end else begin
                model_full = 1'b1;
            end
        end
    endtask

    // ICCM responder
    bit gnt_hold, gnt_block;
    int gnt_delay, wait_cnt;
    always begin
        @(posedge clk_i);
        #1;
        if (gnt_hold) begin
            iccm_gnt_i = 1'b1;
        end else if (gnt_block || !iccm_req_o) begin
            iccm_gnt_i = 1'b0;
            wait_cnt   = 0;
        end else if (wait_cnt >= gnt_delay) begin
            iccm_gnt_i = 1'b1;
        end else begin
            wait_cnt++;
        end
    end

    // Write monitor
    int          req_len = 0;
    logic [31:0] prev_addr, prev_data;
    always @(negedge clk_i) begin
        if (iccm_req_o) begin
            chk("be_req", 32'(iccm_be_o), 32'hF);
            chk("we_req", 32'(iccm_we_o), 32'h1);
            if (req_len > 0) begin
                chk("addr_hold", iccm_addr_o, prev_addr);
                chk("data_hold", iccm_wdata_o, prev_data);
            end
            prev_addr = iccm_addr_o;
            prev_data = iccm_wdata_o;
            req_len++;
            if (iccm_gnt_i) begin
                writes_seen++;
                last_req_len = req_len;
                req_len      = 0;
                chk("wr_expected", 32'(exp_addr_q.size() != 0), 32'h1);
                if (exp_addr_q.size() != 0) begin
                    chk("wr_addr", iccm_addr_o, exp_addr_q.pop_front());
                    chk("wr_data", iccm_wdata_o, exp_data_q.pop_front());
                end
            end
        end else begin
            req_len = 0;
            chk("be_idle", 32'(iccm_be_o), 32'h0);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte_i = b;
        rx_dv_i   = 1'b1;
        tick();
        rx_dv_i   = 1'b0;
        rx_byte_i = 8'($urandom);
    endtask

    task automatic chk_zero_outs(input string pfx);
        chk({pfx, "_req"},  32'(iccm_req_o), 32'h0);
        chk({pfx, "_we"},   32'(iccm_we_o), 32'h0);
        chk({pfx, "_addr"}, iccm_addr_o, 32'h0);
        chk({pfx, "_data"}, iccm_wdata_o, 32'h0);
        chk({pfx, "_be"},   32'(iccm_be_o), 32'h0);
        chk({pfx, "_srst"}, 32'(system_rst_no), 32'h0);
        chk({pfx, "_done"}, 32'(load_done_o), 32'h0);
        chk({pfx, "_cnt"},  32'(word_count_o), 32'h0);
        chk({pfx, "_ovr"},  32'(overrun_o), 32'h0);
        chk({pfx, "_full"}, 32'(full_o), 32'h0);
    endtask

    task automatic do_reset(input string pfx);
        rst_ni    = 1'b0;
        en_i      = 1'b0;
        rx_dv_i   = 1'b0;
        gnt_hold  = 1'b0;
        gnt_block = 1'b0;
        gnt_delay = 0;
        #1;
        chk_zero_outs(pfx);
        exp_addr_q.delete();
        exp_data_q.delete();
        model_count = 0;
        model_full  = 1'b0;
        tick(2);
        rst_ni = 1'b1;
        tick(4);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_addr_q.size() != 0 || iccm_req_o) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 200), 32'h1);
    endtask

    // Sends every word in wlist. With early set, the first byte of the next
    // word may be sent right behind a completed word, while the write is
    // still outstanding.
    task automatic send_stream(input bit early);
        bit          pend;
        logic [31:0] w;
        pend = 1'b0;
        for (int i = 0; i < wlist.size(); i++) begin
            w = wlist[i];
            expect_word(w);
            for (int b = (pend ? 1 : 0); b < 4; b++) begin
                send_byte(w[8*b +: 8]);
                tick($urandom_range(0, 2));
            end
            pend = 1'b0;
            if (early && (i + 1 < wlist.size()) && ($urandom_range(0, 1) == 1)) begin
                w = wlist[i+1];
                send_byte(w[7:0]);
                pend = 1'b1;
            end
            tick(2);
            wait_drain("drain");
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        while (w == END_W) w = $urandom;
        return w;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int          w0;
        logic [31:0] wa, wb;
        logic [7:0]  skid_b;

        rst_ni     = 1'b0;
        en_i       = 1'b0;
        rx_dv_i    = 1'b0;
        rx_byte_i  = 8'h00;
        iccm_gnt_i = 1'b0;
        do_reset("rst0");

        // Basic load with grant held high, including request latency.
        gnt_hold = 1'b1;
        w0 = writes_seen;
        expect_word(32'h0020_0113);
        send_byte(8'h13);
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'h00);
        chk("lat_req_early", 32'(iccm_req_o), 32'h0);
        tick();
        chk("lat_req", 32'(iccm_req_o), 32'h1);
        chk("lat_addr", iccm_addr_o, 32'h0);
        chk("lat_data", iccm_wdata_o, 32'h0020_0113);
        chk("lat_be", 32'(iccm_be_o), 32'hF);
        tick();
        chk("req_drop", 32'(iccm_req_o), 32'h0);
        send_byte(8'hFF);
        send_byte(8'h0F);
        send_byte(8'h00);
        send_byte(8'h00);
        tick(2);
        chk("t1_writes", 32'(writes_seen - w0), 32'd1);
        chk("t1_done", 32'(load_done_o), 32'h1);
        chk("t1_cnt", 32'(word_count_o), 32'd1);
        chk("t1_srst", 32'(system_rst_no), 32'h0);
        en_i = 1'b1;
        tick();
        chk("t1_srst_en", 32'(system_rst_no), 32'h1);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        tick(3);
        chk("t1_run_ignore", 32'(writes_seen - w0), 32'd1);
        chk("t1_run_ovr", 32'(overrun_o), 32'h0);

        // Grant delayed by 5 cycles.
        do_reset("rst1");
        gnt_delay = 5;
        w0 = writes_seen;
        wlist = '{32'h0020_0113, END_W};
        send_stream(1'b0);
        chk("t2_writes", 32'(writes_seen - w0), 32'd1);
        chk("t2_req_len", 32'(last_req_len), 32'd6);
        chk("t2_done", 32'(load_done_o), 32'h1);

        // en_i high throughout the load.
        do_reset("rst2");
        en_i = 1'b1;
        wlist = '{rand_word()};
        send_stream(1'b1);
        chk("t3_srst_load", 32'(system_rst_no), 32'h0);
        send_byte(8'hFF);
        send_byte(8'h0F);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("t3_done_pre", 32'(load_done_o), 32'h0);
        tick();
        chk("t3_done", 32'(load_done_o), 32'h1);
        chk("t3_srst_done", 32'(system_rst_no), 32'h0);
        tick();
        chk("t3_srst_run", 32'(system_rst_no), 32'h1);

        // Two bytes during a stalled write: the first is kept, the second is lost.
        do_reset("rst3");
        gnt_block = 1'b1;
        w0 = writes_seen;
        wa = rand_word();
        expect_word(wa);
        for (int b = 0; b < 4; b++) send_byte(wa[8*b +: 8]);
        tick(2);
        chk("t4_req", 32'(iccm_req_o), 32'h1);
        skid_b = 8'($urandom);
        send_byte(skid_b);
        tick();
        send_byte(8'($urandom));
        chk("t4_ovr", 32'(overrun_o), 32'h1);
        gnt_block = 1'b0;
        wait_drain("t4_drain1");
        wb = {rand_word()};
        wb[7:0] = skid_b;
        expect_word(wb);
        for (int b = 1; b < 4; b++) send_byte(wb[8*b +: 8]);
        tick(2);
        wait_drain("t4_drain2");
        chk("t4_writes", 32'(writes_seen - w0), 32'd2);
        chk("t4_cnt", 32'(word_count_o), 32'd2);
        chk("t4_ovr_sticky", 32'(overrun_o), 32'h1);

        // Capacity: five words into a four-word ICCM.
        do_reset("rst4");
        gnt_delay = 1;
        w0 = writes_seen;
        wlist = '{rand_word(), rand_word(), rand_word(), rand_word(), rand_word(), END_W};
        send_stream(1'b1);
        chk("t5_writes", 32'(writes_seen - w0), 32'd4);
        chk("t5_full", 32'(full_o), 32'h1);
        chk("t5_cnt", 32'(word_count_o), 32'd4);
        chk("t5_done", 32'(load_done_o), 32'h1);

        // Reset while the second write is pending, then reload.
        do_reset("rst5");
        wlist = '{rand_word()};
        send_stream(1'b0);
        gnt_block = 1'b1;
        wa = rand_word();
        expect_word(wa);
        for (int b = 0; b < 4; b++) send_byte(wa[8*b +: 8]);
        tick(2);
        chk("t6_req", 32'(iccm_req_o), 32'h1);
        do_reset("rst_mid");
        w0 = writes_seen;
        wlist = '{rand_word(), END_W};
        send_stream(1'b0);
        chk("t6_writes", 32'(writes_seen - w0), 32'd1);
        chk("t6_cnt", 32'(word_count_o), 32'd1);
        chk("t6_done", 32'(load_done_o), 32'h1);

        // Randomized loads.
        for (int it = 0; it < 8; it++) begin
            do_reset("rst_rand");
            gnt_delay = $urandom_range(0, 3);
            en_i = 1'($urandom_range(0, 1));
            w0 = writes_seen;
            wlist.delete();
            for (int j = 0; j < int'($urandom_range(1, 6)); j++) wlist.push_back(rand_word());
            wlist.push_back(END_W);
            send_stream(1'b1);
            chk("rand_writes", 32'(writes_seen - w0), 32'(model_count));
            chk("rand_cnt", 32'(word_count_o), 32'(model_count));
            chk("rand_full", 32'(full_o), 32'(model_full));
            chk("rand_ovr", 32'(overrun_o), 32'h0);
            chk("rand_done", 32'(load_done_o), 32'h1);
            chk("rand_srst", 32'(system_rst_no), 32'(en_i));
            en_i = 1'b1;
            tick();
            chk("rand_srst_en", 32'(system_rst_no), 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
